// File: rtl/dac_arb_pkg.sv
// Shared types and helpers for the DAC update arbiter.
//   state_e      : FSM encoding (RAMP is only reachable when DAC_RAMP_EN is defined)
//   SETTLE_CNT_W : width of the settle-window down-counter
//   clog2_min1   : ceil(log2(n)) clamped to at least 1, used to size index ports
package dac_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    RAMP   = 2'd2,
    SETTLE = 2'd3
  } state_e;

  localparam int unsigned SETTLE_CNT_W = 16;

  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dac_update_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req     : request vector
//   ptr     : highest-priority index for this pick
//   gnt     : one-hot grant (all zero when no request)
//   gnt_idx : binary index of the granted requester (0 when no request)
module rr_arbiter
  import dac_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W   = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx
);

  logic             found;
  logic [IDX_W-1:0] idx;

  // Scan from ptr upward with wrap; first hit wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = IDX_W'((32'(ptr) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/dac_update_arbiter.sv
// dac_update_arbiter: shares one DAC input between NUM_REQ requesters.
// Round-robin grant, load the granted code, hold it for SETTLE_CYCLES.
// Optional feature macro: DAC_RAMP_EN (slew-limited approach of RAMP_STEP/cycle).
//   clk, rst_n  : clock, async active-low reset
//   req_valid   : per-requester request
//   req_code    : packed codes, requester i at [i*DAC_SIZE +: DAC_SIZE]
//   req_ready   : one-hot accept, only in IDLE (combinational)
//   dac_code    : registered DAC input code
//   dac_load    : strobe in each cycle dac_code shows a new value
//   grant_id    : current/last granted requester
//   busy        : FSM not in IDLE
//   done        : one-cycle pulse at end of settling
module dac_update_arbiter
  import dac_arb_pkg::*;
#(
  parameter  int unsigned DAC_SIZE      = 8,
  parameter  int unsigned NUM_REQ       = 4,
  parameter  int unsigned SETTLE_CYCLES = 16,
  parameter  int unsigned RAMP_STEP     = 4,
  localparam int unsigned GID_W         = clog2_min1(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DAC_SIZE-1:0] req_code,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [DAC_SIZE-1:0]         dac_code,
  output logic                        dac_load,
  output logic [GID_W-1:0]            grant_id,
  output logic                        busy,
  output logic                        done
);

  if (RAMP_STEP == 0) begin : g_bad_ramp_step
    $error("RAMP_STEP must be >= 1");
  end

  localparam logic [SETTLE_CNT_W-1:0] CNT_RELOAD = SETTLE_CNT_W'(SETTLE_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [SETTLE_CNT_W-1:0] cnt_q, cnt_d;
  logic [DAC_SIZE-1:0]     dac_code_q, dac_code_d;
  logic                    dac_load_q, dac_load_d;
  logic [GID_W-1:0]        grant_id_q, grant_id_d;
  logic [GID_W-1:0]        ptr_q, ptr_d;

  logic [NUM_REQ-1:0]      rr_gnt;
  logic [GID_W-1:0]        rr_idx;
  logic                    hs;
  logic [DAC_SIZE-1:0]     sel_code;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt     (rr_gnt),
    .gnt_idx (rr_idx)
  );

  assign sel_code = req_code[32'(rr_idx)*DAC_SIZE +: DAC_SIZE];
  assign hs       = (state_q == IDLE) && (|req_valid);

`ifdef DAC_RAMP_EN
  logic [DAC_SIZE-1:0] target_q, target_d;
  logic [DAC_SIZE-1:0] diff, step;

  // Step size is min(RAMP_STEP, |target - code|), unsigned, never wraps.
  always_comb begin
    diff = (target_q > dac_code_q) ? (target_q - dac_code_q) : (dac_code_q - target_q);
    step = (32'(diff) < RAMP_STEP) ? diff : DAC_SIZE'(RAMP_STEP);
  end
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dac_code_d = dac_code_q;
    dac_load_d = 1'b0;
    grant_id_d = grant_id_q;
    ptr_d      = ptr_q;
`ifdef DAC_RAMP_EN
    target_d   = target_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (hs) begin
          grant_id_d = rr_idx;
          ptr_d      = (rr_idx == GID_W'(NUM_REQ - 1)) ? '0 : rr_idx + GID_W'(1);
`ifdef DAC_RAMP_EN
          target_d   = sel_code;
          state_d    = RAMP;
`else
          // Code register and strobe are written on the handshake edge so the
          // new code and dac_load are both visible during the LOAD cycle.
          dac_code_d = sel_code;
          dac_load_d = 1'b1;
          state_d    = LOAD;
`endif
        end
      end
      LOAD: begin
        cnt_d   = CNT_RELOAD;
        state_d = SETTLE;
      end
`ifdef DAC_RAMP_EN
      RAMP: begin
        if (dac_code_q != target_q) begin
          dac_code_d = (target_q > dac_code_q) ? (dac_code_q + step) : (dac_code_q - step);
          dac_load_d = 1'b1;
        end else begin
          cnt_d   = CNT_RELOAD;
          state_d = SETTLE;
        end
      end
`endif
      SETTLE: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dac_code_q <= '0;
      dac_load_q <= 1'b0;
      grant_id_q <= '0;
      ptr_q      <= '0;
`ifdef DAC_RAMP_EN
      target_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dac_code_q <= dac_code_d;
      dac_load_q <= dac_load_d;
      grant_id_q <= grant_id_d;
      ptr_q      <= ptr_d;
`ifdef DAC_RAMP_EN
      target_q   <= target_d;
`endif
    end
  end

  assign req_ready = (state_q == IDLE) ? rr_gnt : '0;
  assign dac_code  = dac_code_q;
  assign dac_load  = dac_load_q;
  assign grant_id  = grant_id_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == SETTLE) && (cnt_q == '0);

endmodule

// File: tb/tb_dac_update_arbiter.sv
module tb_dac_update_arbiter;

  localparam int DAC_SIZE      = 8;
  localparam int NUM_REQ       = 4;
  localparam int SETTLE_CYCLES = 16;
  localparam int RAMP_STEP     = 4;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_code;
  logic [3:0]  req_ready;
  logic [7:0]  dac_code;
  logic        dac_load;
  logic [1:0]  grant_id;
  logic        busy;
  logic        done;

  dac_update_arbiter #(
    .DAC_SIZE      (DAC_SIZE),
    .NUM_REQ       (NUM_REQ),
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .RAMP_STEP     (RAMP_STEP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_code  (req_code),
    .req_ready (req_ready),
    .dac_code  (dac_code),
    .dac_load  (dac_load),
    .grant_id  (grant_id),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         gid;
    logic [7:0] code;
  } item_t;

  item_t sb[$];
  int    gid_log[$];

  int checks = 0;
  int errors = 0;

  // Reference timeline, in cycles counted from reset release.
  int         cyc;
  int         m_ptr, hs_cyc, done_cyc, load_first, load_last, hs_count;
  int         gid_next, gid_from, e_gid;
  logic [7:0] e_code, last_tgt;
  logic       prev_load;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] v, input int ptr);
    for (int k = 0; k < 4; k++) begin
      int i = (ptr + k) % 4;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    sb.delete();
    m_ptr = 0; hs_cyc = -100; done_cyc = -100;
    load_first = -100; load_last = -101;
    gid_next = 0; gid_from = 1 << 30; e_gid = 0;
    e_code = 8'h00; last_tgt = 8'h00; prev_load = 1'b0;
    cyc = 0;
  endtask

  task automatic tick();
    int         p;
    logic [3:0] er;
    logic       idle, exp_load;
    item_t      it;
    int         ci, cur;
    #1;
    idle = (cyc > done_cyc);
    p    = idle ? pick(req_valid, m_ptr) : -1;
    er   = 4'b0000;
    if (p >= 0) er[p] = 1'b1;
    if (cyc >= gid_from) e_gid = gid_next;
    exp_load = (cyc >= load_first) && (cyc <= load_last);

    check("req_ready", req_ready, er);
    check("dac_load", dac_load, exp_load);
    check("busy", busy, (cyc > hs_cyc) && (cyc <= done_cyc));
    check("done", done, cyc == done_cyc);
    check("grant_id", grant_id, e_gid);
    if (exp_load) begin
      if (sb.size() == 0) begin
        check("sb_nonempty", 32'(sb.size()), 1);
      end else begin
        it = sb.pop_front();
        e_code = it.code;
        check("sb_code", dac_code, it.code);
        check("sb_gid", grant_id, it.gid);
      end
    end else begin
      check("dac_code_hold", dac_code, e_code);
    end
    if (dac_load === 1'b1 && !prev_load) gid_log.push_back(int'(grant_id));
    prev_load = dac_load;

    if (p >= 0) begin
      ci       = int'(req_code[p*8 +: 8]);
      hs_cyc   = cyc;
      hs_count++;
      m_ptr    = (p + 1) % 4;
      gid_next = p;
      gid_from = cyc + 1;
`ifdef DAC_RAMP_EN
      begin
        int n = 0;
        cur = int'(last_tgt);
        while (cur != ci) begin
          if (ci > cur) cur = (ci - cur < RAMP_STEP) ? ci : cur + RAMP_STEP;
          else          cur = (cur - ci < RAMP_STEP) ? ci : cur - RAMP_STEP;
          sb.push_back('{p, 8'(cur)});
          n++;
        end
        load_first = cyc + 2;
        load_last  = cyc + 1 + n;
        done_cyc   = cyc + 1 + n + SETTLE_CYCLES;
      end
`else
      cur = ci;
      sb.push_back('{p, 8'(cur)});
      load_first = cyc + 1;
      load_last  = cyc + 1;
      done_cyc   = cyc + 1 + SETTLE_CYCLES;
`endif
      last_tgt = 8'(ci);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = 4'b0000;
    #1;
    check("rst_dac_code", dac_code, 0);
    check("rst_dac_load", dac_load, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_req_ready", req_ready, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic run_until_idle();
    int guard = 0;
    while (cyc <= done_cyc && guard < 600) begin
      tick();
      guard++;
    end
    check("idle_within_bound", guard < 600, 1);
    tick();
  endtask

  task automatic run_hs(input int target);
    int guard = 0;
    while (hs_count < target && guard < 2000) begin
      tick();
      guard++;
    end
    check("handshakes_within_bound", guard < 2000, 1);
  endtask

  initial begin
    int exp_order[5] = '{0, 1, 2, 3, 0};
    req_code = 32'h0;
    hs_count = 0;
    model_reset();
    do_reset();

    // Single request from requester 0 right after reset release.
    req_code  = 32'h0000_005A;
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0000;
    run_until_idle();

    // All four requesters continuously valid: rotation 0,1,2,3,0.
    do_reset();
    gid_log.delete();
    req_code  = 32'h4030_2010;
    req_valid = 4'b1111;
    run_hs(hs_count + 5);
    req_valid = 4'b0000;
    run_until_idle();
    check("fair_count", 32'(gid_log.size()), 5);
    for (int i = 0; i < 5 && i < gid_log.size(); i++) check("fair_order", gid_log[i], exp_order[i]);

    // Asynchronous reset in the middle of a transaction.
    do_reset();
    req_code  = 32'h0000_00FF;
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0000;
    while (cyc < hs_cyc + 6) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_dac_code", dac_code, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    check("async_rst_load", dac_load, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    req_code  = 32'h0000_2211;
    req_valid = 4'b0011;
    tick();
    req_valid = 4'b0000;
    run_until_idle();

    // Same code twice from requester 2.
    req_code  = 32'h0033_0000;
    req_valid = 4'b0100;
    run_hs(hs_count + 2);
    req_valid = 4'b0000;
    run_until_idle();

    // Requester 1 pulses valid during SETTLE only, then withdraws.
    req_code  = 32'h7700_5500;
    req_valid = 4'b1000;
    tick();
    req_valid = 4'b0000;
    while (cyc < done_cyc - 3) tick();
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b0000;
    run_until_idle();
    for (int i = 0; i < 3; i++) tick();

    // Slew sequence: 0x00 -> 0x0A, then 0x0A -> 0x02.
    do_reset();
    req_code  = 32'h0000_000A;
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0000;
    run_until_idle();
    req_code  = 32'h0000_0002;
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0000;
    run_until_idle();

    check("sb_drained", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dac_update_arbiter.md
Name: dac_update_arbiter

Overview:
- Shares one DAC_SIZE-bit converter input between NUM_REQ digital requesters.
- Round-robin arbitration between requesters; each granted code is loaded into the DAC, then held for a settling window before the next grant.
- Sits in the digital wrapper in front of the DAC model. dac_code drives the DAC input bits; done tells software/sequencers that the analog output has settled.

Parameters:
- DAC_SIZE, 8, DAC code width in bits (>=2).
- NUM_REQ, 4, number of requesters (>=2).
- SETTLE_CYCLES, 16, number of cycles the code is held after load (1..65535).
- RAMP_STEP, 4, maximum code change per cycle in ramp mode (>=1). Used only with DAC_RAMP_EN.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: asynchronous active-low reset.
- req_valid, in, NUM_REQ: per-requester request.
- req_code, in, NUM_REQ*DAC_SIZE: codes; requester i uses bits [i*DAC_SIZE +: DAC_SIZE].
- req_ready, out, NUM_REQ: one-hot accept, combinational.
- dac_code, out, DAC_SIZE: registered code to the DAC.
- dac_load, out, 1: one-cycle strobe; high in the same cycle that dac_code takes a new value.
- grant_id, out, clog2(NUM_REQ): index of the current/last granted requester.
- busy, out, 1: high whenever the FSM is not in IDLE.
- done, out, 1: one-cycle pulse at the end of settling.

Behaviour:
- Clocking and reset: one clock, clk; reset is asynchronous, active-low, rst_n.
- Reset values: dac_code=0, dac_load=0, grant_id=0, busy=0, done=0, req_ready=0, state=IDLE. The round-robin pointer is reset so requester 0 has top priority.
- Reset asserted mid-operation: aborts the transaction immediately and dac_code returns to 0. No done pulse is issued.
- FSM states: IDLE, LOAD, RAMP (only with the macro), SETTLE.
- IDLE:
  - req_ready is asserted only in IDLE, one-hot, to the first valid requester at or after (last grant + 1) mod NUM_REQ.
  - A handshake (valid & ready) in cycle A captures the code into target, sets grant_id, and moves to LOAD.
  - No valid request: stay in IDLE; all outputs except dac_code and grant_id are 0.
- LOAD (cycle A+1):
  - dac_code <= target; dac_load=1; busy=1; settle counter loaded with SETTLE_CYCLES-1; next state SETTLE.
- SETTLE:
  - Counter decrements once per cycle.
  - When the counter is 0: done=1 for that cycle and next state IDLE.
  - With the standard path, done occurs in cycle A+1+SETTLE_CYCLES; the earliest next handshake is cycle A+2+SETTLE_CYCLES.
- The round-robin pointer updates at the handshake. A requester holding valid continuously cannot starve the others.
- A code equal to the current dac_code still executes LOAD plus a full SETTLE window. Same-value updates are not skipped.
- Requesters may drop valid before ready without side effects. req_code is sampled only in the handshake cycle.
- Between transactions, dac_code holds its last value. grant_id holds until the next grant.

Optional Feature:
- Macro: DAC_RAMP_EN.
- Defined:
  - The handshake moves the FSM to RAMP instead of LOAD.
  - In each RAMP cycle, if dac_code != target, dac_code moves toward target by min(RAMP_STEP, |target-dac_code|) using unsigned compare, with no wrap. dac_load=1 in every step cycle.
  - When dac_code == target, no strobe is issued, the counter is loaded, and the FSM goes to SETTLE.
  - A target already equal to dac_code spends one RAMP cycle with no strobe.
- Undefined:
  - No RAMP state and no RAMP_STEP logic; the single-jump LOAD behaviour above applies.

Decomposition:
- Package dac_arb_pkg holds:
  - the state enum (IDLE/LOAD/RAMP/SETTLE);
  - the function clog2_min1, which returns at least 1 and sizes grant_id;
  - the settle counter width constant (16).
- Sub-module rr_arbiter (NUM_REQ): inputs are the request vector and pointer; outputs are the one-hot grant and index. It is purely combinational and reused by other shared-resource blocks.

Test Plan:
- Reset check: release rst_n; req0 valid with code 0x5A at cycle 0 -> req_ready=0001 at cycle 0; dac_code=0x5A with dac_load=1 at cycle 1; done at cycle 17; busy low at cycle 18.
- Fairness: all 4 requesters valid with codes 0x10/0x20/0x30/0x40 -> grants in order 0,1,2,3,0. Each done is 16 cycles after its load, and dac_code follows the same sequence.
- Reset mid-operation: pull rst_n low in SETTLE after loading 0xFF -> dac_code=0, busy=0 asynchronously, no done. After release, requester 0 has priority again.
- Repeated code: load 0x33 twice from requester 2 alone -> two dac_load pulses and two full 16-cycle windows; grant_id=2 both times.
- Withdrawn request: req1 valid for one cycle while the FSM is in SETTLE, then dropped -> no grant to req1; the FSM returns to IDLE with req_ready=0.
- DAC_RAMP_EN, RAMP_STEP=4: target 0x0A from 0x00 -> dac_code 4, 8, 10 with 3 dac_load pulses. Then target 0x02 -> 6, 2. done occurs SETTLE_CYCLES cycles after the ramp completes.
